// File: rtl/adis_spi_slave_pkg.sv
// Shared ADIS frame layout and constants for the SPI responder.
package adis_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned REG_IDX_W  = 6;
  localparam int unsigned CNT_W      = 5;
  localparam logic [FRAME_BITS-1:0] PEND_RST = 16'h0000;

  // Frame layout: W at bit 15, byte address at 14:8, data at 7:0
  typedef struct packed {
    logic              w;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } adis_frame_t;

  // Byte address to 16-bit register index
  function automatic logic [REG_IDX_W-1:0] reg_idx(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:1];
  endfunction

endpackage

// File: rtl/adis_spi_slave_edge_sync.sv
// Multi-flop synchronizer with rise/fall pulses; edges are suppressed until
// the chain has been refilled after reset so a held level is never an edge.
module spi_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise_c,
  output logic fall_c
);

  logic [SYNC_STAGES:0] sh;
  logic [SYNC_STAGES:0] vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh  <= {(SYNC_STAGES + 1){RST_VAL}};
      vld <= '0;
    end else begin
      sh  <= {sh[SYNC_STAGES-1:0], din};
      vld <= {vld[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign rise_c = vld[SYNC_STAGES] &  sh[SYNC_STAGES-1] & ~sh[SYNC_STAGES];
  assign fall_c = vld[SYNC_STAGES] & ~sh[SYNC_STAGES-1] &  sh[SYNC_STAGES];

endmodule

// File: rtl/adis_spi_slave.sv
// ADIS-style SPI mode-3 responder with pipelined read data and local write port.
// Optional CS inter-frame stall check enabled by defining ADIS_STALL_CHK_EN.
module adis_spi_slave
  import adis_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NWORDS      = 64
`ifdef ADIS_STALL_CHK_EN
  , parameter int unsigned STALL_CYC = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic                  lw_en,
  input  logic [REG_IDX_W-1:0]  lw_addr,
  input  logic [FRAME_BITS-1:0] lw_data,
  output logic                  frame_done,
  output logic                  frame_err,
  output logic [FRAME_BITS-1:0] cmd
`ifdef ADIS_STALL_CHK_EN
  , output logic                stall_err
`endif
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_FRAME = 1'b1;

  logic                  sclk_rise, sclk_fall_unused;
  logic                  cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sh;
  logic                  mosi_s;
  logic                  st, st_nxt;
  logic [CNT_W-1:0]      bit_cnt;
  logic [FRAME_BITS-1:0] rx, tx, pend, pend_nxt;
  logic                  dec_pend;
  logic                  frame_stall;
  logic [FRAME_BITS-1:0] regs [NWORDS];
  adis_frame_t           f;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
    .clk(clk), .rst(rst), .din(sclk), .rise_c(sclk_rise), .fall_c(sclk_fall_unused)
  );

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .din(cs), .rise_c(cs_rise), .fall_c(cs_fall)
  );

  // MOSI has the same depth as the SCLK path, keeping data aligned to the edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mosi_sh <= '0;
    else     mosi_sh <= {mosi_sh[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_s = mosi_sh[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= ST_IDLE;
    else     st <= st_nxt;
  end

  // A frame is only entered on a seen CS fall; reset mid-frame stays idle
  always_comb begin
    st_nxt = st;
    case (st)
      ST_IDLE:  if (cs_fall) st_nxt = ST_FRAME;
      ST_FRAME: if (cs_rise) st_nxt = ST_IDLE;
      default:  st_nxt = ST_IDLE;
    endcase
  end

  assign f = adis_frame_t'(cmd);

  always_comb begin
    pend_nxt = pend;
    if (dec_pend) pend_nxt = f.w ? PEND_RST : regs[reg_idx(f.addr)];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt    <= '0;
      rx         <= '0;
      tx         <= '0;
      pend       <= PEND_RST;
      miso       <= 1'b0;
      miso_oe    <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      dec_pend   <= 1'b0;
      cmd        <= '0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      dec_pend   <= 1'b0;
      pend       <= pend_nxt;
      if (cs_fall) begin
        bit_cnt <= '0;
        tx      <= pend_nxt;
      end else if (st == ST_FRAME && sclk_rise) begin
        rx <= {rx[FRAME_BITS-2:0], mosi_s};
        tx <= {tx[FRAME_BITS-2:0], 1'b0};
        if (bit_cnt != CNT_W'(FRAME_BITS + 1)) bit_cnt <= bit_cnt + CNT_W'(1);
      end
      miso    <= (st == ST_FRAME && !cs_rise) ? tx[FRAME_BITS-1] : 1'b0;
      miso_oe <= (st_nxt == ST_FRAME);
      if (cs_rise) begin
        if (bit_cnt == CNT_W'(FRAME_BITS)) begin
          cmd        <= rx;
          frame_done <= 1'b1;
          dec_pend   <= ~frame_stall;
        end else begin
          frame_err  <= 1'b1;
        end
      end
    end
  end

  // Register file: local port is written last so it wins a same-word collision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NWORDS; i++) regs[i] <= '0;
    end else begin
      if (dec_pend && f.w) begin
        if (f.addr[0]) regs[reg_idx(f.addr)][15:8] <= f.data;
        else           regs[reg_idx(f.addr)][7:0]  <= f.data;
      end
      if (lw_en) regs[lw_addr] <= lw_data;
    end
  end

`ifdef ADIS_STALL_CHK_EN
  localparam int unsigned GAP_W = $clog2(STALL_CYC + 1);
  logic [GAP_W-1:0] gap_cnt;

  // Counts clk cycles since the synced CS rise, saturating at STALL_CYC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_cnt     <= GAP_W'(STALL_CYC);
      stall_err   <= 1'b0;
      frame_stall <= 1'b0;
    end else begin
      if (cs_rise)                            gap_cnt <= '0;
      else if (gap_cnt < GAP_W'(STALL_CYC))   gap_cnt <= gap_cnt + GAP_W'(1);
      if (cs_fall) begin
        frame_stall <= (gap_cnt < GAP_W'(STALL_CYC));
        if (gap_cnt < GAP_W'(STALL_CYC)) stall_err <= 1'b1;
      end
    end
  end
`else
  assign frame_stall = 1'b0;
`endif

endmodule

// File: tb/tb_adis_spi_slave.sv
// Randomized bench for adis_spi_slave against a frame-level register/pending model.
// Build with ADIS_STALL_CHK_EN defined to exercise the stall check.
module tb_adis_spi_slave;

  logic        clk = 1'b0;
  logic        rst, sclk, cs, mosi, lw_en;
  logic [5:0]  lw_addr;
  logic [15:0] lw_data;
  logic        miso, miso_oe, frame_done, frame_err;
  logic [15:0] cmd;
`ifdef ADIS_STALL_CHK_EN
  logic        stall_err;
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  int n_chk = 0;
  int n_pass = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  logic [15:0] m_regs [64];
  logic [15:0] m_pend;
  logic [15:0] m_cmd;

  always #5 clk = ~clk;

  adis_spi_slave dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe),
    .lw_en(lw_en), .lw_addr(lw_addr), .lw_data(lw_data),
    .frame_done(frame_done), .frame_err(frame_err), .cmd(cmd)
`ifdef ADIS_STALL_CHK_EN
    , .stall_err(stall_err)
`endif
  );

  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (frame_err)  err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_regs[i] = 16'h0000;
    m_pend = 16'h0000;
    m_cmd  = 16'h0000;
  endtask

  // Frame-level model: miso returns the old pending word; a full frame decodes
  task automatic model_frame(input logic [15:0] w, input int nbits, input bit stalled,
                             output logic [31:0] exp_miso, output int ed, output int ee);
    logic [5:0] idx;
    bit b;
    exp_miso = '0;
    for (int i = 0; i < nbits; i++) begin
      b = (i < 16) ? m_pend[15-i] : 1'b0;
      exp_miso = {exp_miso[30:0], b};
    end
    idx = w[14:9];
    if (nbits == 16) begin
      ed = 1; ee = 0; m_cmd = w;
      if (!stalled) begin
        if (w[15]) begin
          if (w[8]) m_regs[idx][15:8] = w[7:0];
          else      m_regs[idx][7:0]  = w[7:0];
          m_pend = 16'h0000;
        end else begin
          m_pend = m_regs[idx];
        end
      end
    end else begin
      ed = 0; ee = 1;
    end
  endtask

  task automatic local_wr(input logic [5:0] a, input logic [15:0] d);
    lw_en = 1'b1; lw_addr = a; lw_data = d;
    @(negedge clk);
    lw_en = 1'b0;
    m_regs[a] = d;
  endtask

  // Master side: mode 3, MOSI changes on falling SCLK, MISO sampled before rising
  task automatic spi_frame(input logic [15:0] w, input int nbits, input int gap,
                           input bit coll, input logic [5:0] ca, input logic [15:0] cd,
                           output logic [31:0] got);
    logic [31:0] sh;
    bit pend_coll;
    sh = {w, 16'h0000};
    got = '0;
    pend_coll = coll;
    cs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b0; mosi = sh[31]; sh = sh << 1;
      repeat (5) @(negedge clk);
      got = {got[30:0], miso};
      sclk = 1'b1;
      repeat (5) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    cs = 1'b1;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      lw_en = 1'b0;
      if (pend_coll && frame_done) begin
        lw_en = 1'b1; lw_addr = ca; lw_data = cd; pend_coll = 1'b0;
      end
    end
    lw_en = 1'b0;
  endtask

  task automatic do_frame(input logic [15:0] w, input int nbits, input int gap, input bit stalled,
                          input bit coll, input logic [5:0] ca, input logic [15:0] cd, input string tag);
    logic [31:0] got, exp_miso;
    int ed, ee, d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    model_frame(w, nbits, stalled, exp_miso, ed, ee);
    if (coll) m_regs[ca] = cd;
    spi_frame(w, nbits, gap, coll, ca, cd, got);
    check({tag, "_miso"}, got, exp_miso);
    check({tag, "_done"}, 32'(done_cnt - d0), 32'(ed));
    check({tag, "_err"},  32'(err_cnt - e0),  32'(ee));
    check({tag, "_cmd"},  32'(cmd), 32'(m_cmd));
  endtask

  initial begin
    int bad, d0, e0;
    rst = 1'b1; sclk = 1'b1; cs = 1'b1; mosi = 1'b0;
    lw_en = 1'b0; lw_addr = '0; lw_data = '0;
    model_reset();
    repeat (5) @(negedge clk);
    rst = 1'b0;

    // Idle after reset: quiet outputs, no pulses
    bad = 0; d0 = done_cnt; e0 = err_cnt;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (miso !== 1'b0 || miso_oe !== 1'b0 || cmd !== 16'h0000) bad++;
    end
    check("idle_outputs", 32'(bad), 32'd0);
    check("idle_pulses", 32'(done_cnt - d0 + err_cnt - e0), 32'd0);
`ifdef ADIS_STALL_CHK_EN
    check("idle_stall", 32'(stall_err), 32'd0);
`endif

    // Pipelined read of a locally written word
    local_wr(6'h05, 16'hA5C3);
    do_frame(16'h0A00, 16, 20, 1'b0, 1'b0, '0, '0, "rd5");
    do_frame(16'h0000, 16, 20, 1'b0, 1'b0, '0, '0, "rd5_data");

    // SPI byte writes then readback
    do_frame(16'h8C34, 16, 20, 1'b0, 1'b0, '0, '0, "wr6_lo");
    do_frame(16'h8D12, 16, 20, 1'b0, 1'b0, '0, '0, "wr6_hi");
    do_frame(16'h0C00, 16, 20, 1'b0, 1'b0, '0, '0, "rd6");
    do_frame(16'h0000, 16, 20, 1'b0, 1'b0, '0, '0, "rd6_data");

    // Short frame keeps cmd and pending; overrun frame also errors
    do_frame(16'h0C00, 16, 20, 1'b0, 1'b0, '0, '0, "rd6_again");
    do_frame(16'h8AFF, 9,  20, 1'b0, 1'b0, '0, '0, "short9");
    do_frame(16'h1234, 18, 20, 1'b0, 1'b0, '0, '0, "over18");
    do_frame(16'h0000, 16, 20, 1'b0, 1'b0, '0, '0, "after_err");

    // Local write lands in the same cycle as an SPI write decode to that word
    do_frame(16'h8A77, 16, 20, 1'b0, 1'b1, 6'h05, 16'hBEEF, "coll");
    do_frame(16'h0A00, 16, 20, 1'b0, 1'b0, '0, '0, "coll_rd");
    do_frame(16'h0000, 16, 20, 1'b0, 1'b0, '0, '0, "coll_data");

    // Randomized mix over a small address window
    for (int it = 0; it < 40; it++) begin
      int r, nb;
      bit co;
      logic [15:0] w;
      r = int'($urandom_range(0, 9));
      if (r < 2) begin
        local_wr(6'($urandom_range(0, 7)), 16'($urandom));
      end else begin
        w = 16'($urandom);
        w[14:9] = 6'($urandom_range(0, 7));
        nb = 16;
        if (r == 9) nb = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 15))
                                                      : int'($urandom_range(17, 19));
        co = (r == 8) && w[15];
        do_frame(w, nb, 20, 1'b0, co, w[14:9], 16'($urandom), "rand");
      end
    end

    // Reset in the middle of a read frame
    do_frame(16'h0A00, 16, 20, 1'b0, 1'b0, '0, '0, "pre_rst");
    cs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      sclk = 1'b0; mosi = 1'b1; repeat (5) @(negedge clk);
      sclk = 1'b1; repeat (5) @(negedge clk);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_oe", 32'(miso_oe), 32'd0);
    check("rst_cmd", 32'(cmd), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    model_reset();
    d0 = done_cnt; e0 = err_cnt; bad = 0;
    for (int i = 0; i < 8; i++) begin
      sclk = 1'b0; mosi = 1'b0; repeat (5) @(negedge clk);
      if (miso !== 1'b0 || miso_oe !== 1'b0) bad++;
      sclk = 1'b1; repeat (5) @(negedge clk);
      if (miso !== 1'b0 || miso_oe !== 1'b0) bad++;
    end
    repeat (2) @(negedge clk);
    cs = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_tail_quiet", 32'(bad), 32'd0);
    check("rst_tail_err", 32'(err_cnt - e0), 32'd1);
    check("rst_tail_done", 32'(done_cnt - d0), 32'd0);
    local_wr(6'h05, 16'h00FF);
    do_frame(16'h0A00, 16, 20, 1'b0, 1'b0, '0, '0, "post_rst_rd");
    do_frame(16'h0000, 16, 20, 1'b0, 1'b0, '0, '0, "post_rst_data");

    // Back-to-back frames with a short CS-high gap
    do_frame(16'h8E55, 16, 5,  1'b0,     1'b0, '0, '0, "gap_a");
    do_frame(16'h8F66, 16, 20, STALL_EN, 1'b0, '0, '0, "gap_b");
    do_frame(16'h0E00, 16, 20, 1'b0,     1'b0, '0, '0, "gap_rd");
    do_frame(16'h0000, 16, 20, 1'b0,     1'b0, '0, '0, "gap_data");
`ifdef ADIS_STALL_CHK_EN
    check("stall_err", 32'(stall_err), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
